alu_result_stage: RTL and testbench

- Downstream stage of the 16-bit ALU. Captures each ALU result y and its SVNZC flags.
- Results queue in a 2-entry FIFO. The FIFO drains to the register-file write port over a valid/ready handshake.
- Keeps the architectural status register (SR) with a per-opcode flag-update mask.
- Evaluates branch conditions against SR for the fetch/branch unit.

---
 rtl/alu_result_stage_pkg.sv | 39 +++
 rtl/alu_result_stage_if.sv | 28 ++
 rtl/alu_result_stage_wb_fifo2.sv | 67 ++++++
 rtl/alu_result_stage.sv | 92 +++++++++
 tb/tb_alu_result_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared constants and types for the ALU result stage.
// Covers opcodes, condition codes, SR flag bit positions and the write-back entry.
package alu_result_stage_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_SUB = 4'd1;
    localparam logic [3:0] ALU_OP_MUL = 4'd2;
    localparam logic [3:0] ALU_OP_AND = 4'd3;
    localparam logic [3:0] ALU_OP_OR  = 4'd4;
    localparam logic [3:0] ALU_OP_XOR = 4'd5;
    localparam logic [3:0] ALU_OP_NOR = 4'd6;
    localparam logic [3:0] ALU_OP_SLL = 4'd7;
    localparam logic [3:0] ALU_OP_SRL = 4'd8;
    localparam logic [3:0] ALU_OP_ROL = 4'd9;
    localparam logic [3:0] ALU_OP_SWP = 4'd10;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_S = 4;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC,
        COND_MI, COND_PL, COND_VS, COND_VC,
        COND_LT, COND_GE, COND_GT, COND_LE,
        COND_HI, COND_LS, COND_AL, COND_NV
    } cond_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-result input handshake and register-file write-back handshake.
interface alu_result_stage_if;
    import alu_result_stage_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_ctrl;
    logic [DATA_W-1:0] in_y;
    logic [4:0]        in_flags;
    logic [ADDR_W-1:0] in_dest;
    logic              in_wen;
    logic              in_fwe;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output in_valid, in_ctrl, in_y, in_flags, in_dest, in_wen, in_fwe, wb_ready,
        input  in_ready, wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_y, in_flags, in_dest, in_wen, in_fwe, wb_ready,
        output in_ready, wb_valid, wb_addr, wb_data
    );

endinterface

// File: rtl/alu_result_stage_wb_fifo2.sv
// Two-entry write-back FIFO; head entry is read straight from register storage.
// No bypass: a full FIFO reports not-ready even when it is popped that cycle.
module wb_fifo2
    import alu_result_stage_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t din,
    output logic      ready,
    input  logic      pop_ready,
    output logic      valid,
    output wb_entry_t dout
);

    localparam logic [1:0] FULL_COUNT = 2'd2;

    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic       push_ok;
    logic       pop_ok;
    wb_entry_t  mem_reg [DEPTH];

    assign valid   = (count_reg != 2'd0);
    assign ready   = (count_reg != FULL_COUNT);
    assign push_ok = push & ready;
    assign pop_ok  = valid & pop_ready;
    assign dout    = mem_reg[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // Storage is cleared on reset so the idle head reads back as zero.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: queues write-backs, maintains the status register and
// evaluates branch conditions against the registered SR.
module alu_result_stage
    import alu_result_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    alu_result_stage_if.slave bus,
    input  logic              sr_load,
    input  logic [4:0]        sr_wdata,
    output logic [4:0]        sr,
    input  logic [3:0]        cond_sel,
    output logic              cond_true
);

    logic      accept;
    logic      fifo_ready;
    logic      fifo_valid;
    wb_entry_t fifo_din;
    wb_entry_t fifo_dout;
    logic [4:0] flag_mask;
    logic [4:0] sr_reg;

    assign accept        = bus.in_valid & fifo_ready;
    assign bus.in_ready  = fifo_ready;
    assign fifo_din.addr = bus.in_dest;
    assign fifo_din.data = bus.in_y;

    wb_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept & bus.in_wen),
        .din       (fifo_din),
        .ready     (fifo_ready),
        .pop_ready (bus.wb_ready),
        .valid     (fifo_valid),
        .dout      (fifo_dout)
    );

    assign bus.wb_valid = fifo_valid;
    assign bus.wb_addr  = fifo_dout.addr;
    assign bus.wb_data  = fifo_dout.data;

    // Arithmetic ops own every flag; logic/shift/mul ops only N and Z.
    always_comb begin
        flag_mask = '0;
        case (bus.in_ctrl)
            ALU_OP_ADD, ALU_OP_SUB: flag_mask = '1;
            ALU_OP_MUL, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_NOR,
            ALU_OP_SLL, ALU_OP_SRL, ALU_OP_ROL, ALU_OP_SWP: begin
                flag_mask[FLAG_N] = 1'b1;
                flag_mask[FLAG_Z] = 1'b1;
            end
            default: flag_mask = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_reg <= '0;
        end else if (sr_load) begin
            sr_reg <= sr_wdata;
        end else if (accept && bus.in_fwe) begin
            sr_reg <= (sr_reg & ~flag_mask) | (bus.in_flags & flag_mask);
        end
    end

    assign sr = sr_reg;

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond_sel))
            COND_EQ: cond_true =  sr_reg[FLAG_Z];
            COND_NE: cond_true = ~sr_reg[FLAG_Z];
            COND_CS: cond_true =  sr_reg[FLAG_C];
            COND_CC: cond_true = ~sr_reg[FLAG_C];
            COND_MI: cond_true =  sr_reg[FLAG_N];
            COND_PL: cond_true = ~sr_reg[FLAG_N];
            COND_VS: cond_true =  sr_reg[FLAG_V];
            COND_VC: cond_true = ~sr_reg[FLAG_V];
            COND_LT: cond_true =  sr_reg[FLAG_S];
            COND_GE: cond_true = ~sr_reg[FLAG_S];
            COND_GT: cond_true = ~sr_reg[FLAG_Z] & ~sr_reg[FLAG_S];
            COND_LE: cond_true =  sr_reg[FLAG_Z] |  sr_reg[FLAG_S];
            COND_HI: cond_true =  sr_reg[FLAG_C] & ~sr_reg[FLAG_Z];
            COND_LS: cond_true = ~sr_reg[FLAG_C] |  sr_reg[FLAG_Z];
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic compared every cycle against a queue-based behavioural model.
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       sr_load;
    logic [4:0] sr_wdata;
    logic [4:0] sr_w;
    logic [3:0] cond_sel;
    logic       cond_true_w;

    int checks = 0;
    int errors = 0;

    alu_result_stage_if bus ();

    alu_result_stage dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sr_load   (sr_load),
        .sr_wdata  (sr_wdata),
        .sr        (sr_w),
        .cond_sel  (cond_sel),
        .cond_true (cond_true_w)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of pending write-backs and the SR value.
    wb_entry_t  q[$];
    logic [4:0] sr_m;

    function automatic logic cond_ref(logic [4:0] s, logic [3:0] sel);
        logic fs, fv, fn, fz, fc;
        {fs, fv, fn, fz, fc} = s;
        case (sel)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fn;
            4'd5:  return !fn;
            4'd6:  return fv;
            4'd7:  return !fv;
            4'd8:  return fs;
            4'd9:  return !fs;
            4'd10: return !fz && !fs;
            4'd11: return fz || fs;
            4'd12: return fc && !fz;
            4'd13: return !fc || fz;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit acc, pop;
        wb_entry_t e;
        if (reset) begin
            q.delete();
            sr_m = 5'b0;
        end else begin
            acc = bus.in_valid && (q.size() < 2);
            pop = bus.wb_ready && (q.size() > 0);
            if (pop) begin
                $display("wb  addr=%0d data=%04h", q[0].addr, q[0].data);
                void'(q.pop_front());
            end
            if (acc && bus.in_wen) begin
                e.addr = bus.in_dest;
                e.data = bus.in_y;
                q.push_back(e);
            end
            if (sr_load) begin
                sr_m = sr_wdata;
            end else if (acc && bus.in_fwe) begin
                if (bus.in_ctrl == ALU_OP_ADD || bus.in_ctrl == ALU_OP_SUB)
                    sr_m = bus.in_flags;
                else if (bus.in_ctrl >= ALU_OP_MUL && bus.in_ctrl <= ALU_OP_SWP)
                    sr_m = {sr_m[4], sr_m[3], bus.in_flags[2], bus.in_flags[1], sr_m[0]};
            end
        end
    endtask

    task automatic compare_all();
        chk("wb_valid", bus.wb_valid, q.size() != 0);
        chk("in_ready", bus.in_ready, q.size() < 2);
        chk("sr", sr_w, sr_m);
        chk("cond_true", cond_true_w, cond_ref(sr_m, cond_sel));
        if (q.size() != 0) begin
            chk("wb_addr", bus.wb_addr, q[0].addr);
            chk("wb_data", bus.wb_data, q[0].data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_in(input logic [3:0] op, input logic [15:0] y, input logic [4:0] fl,
                          input logic [3:0] dest, input logic wen, input logic fwe);
        bus.in_valid = 1'b1;
        bus.in_ctrl  = op;
        bus.in_y     = y;
        bus.in_flags = fl;
        bus.in_dest  = dest;
        bus.in_wen   = wen;
        bus.in_fwe   = fwe;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        sr_load      = 1'b0;
    endtask

    task automatic cond_lit(input string name, input cond_e c, input logic exp);
        cond_sel = c;
        #1;
        chk(name, cond_true_w, exp);
    endtask

    initial begin
        reset = 1'b1;
        sr_load = 1'b0;
        sr_wdata = 5'b0;
        cond_sel = 4'd0;
        bus.wb_ready = 1'b0;
        set_in(ALU_OP_ADD, 16'h0, 5'b0, 4'd0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        step();
        step();
        chk("rst_wb_valid", bus.wb_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_wb_addr", bus.wb_addr, 4'd0);
        chk("rst_wb_data", bus.wb_data, 16'h0);
        chk("rst_sr", sr_w, 5'b00000);
        reset = 1'b0;

        // ADD result and full flag update
        bus.wb_ready = 1'b1;
        set_in(ALU_OP_ADD, 16'h8000, 5'b10100, 4'd3, 1'b1, 1'b1);
        step();
        idle();
        chk("add_wb_valid", bus.wb_valid, 1'b1);
        chk("add_wb_addr", bus.wb_addr, 4'd3);
        chk("add_wb_data", bus.wb_data, 16'h8000);
        chk("add_sr", sr_w, 5'b10100);
        cond_lit("add_lt", COND_LT, 1'b1);
        cond_lit("add_mi", COND_MI, 1'b1);
        cond_lit("add_eq", COND_EQ, 1'b0);
        step();

        // Logic op updates only N,Z
        sr_load = 1'b1;
        sr_wdata = 5'b01001;
        step();
        sr_load = 1'b0;
        set_in(ALU_OP_AND, 16'h1234, 5'b00010, 4'd5, 1'b0, 1'b1);
        step();
        idle();
        chk("and_sr", sr_w, 5'b01011);
        chk("and_no_push", bus.wb_valid, 1'b0);
        cond_lit("and_eq", COND_EQ, 1'b1);
        cond_lit("and_vs", COND_VS, 1'b1);

        // Backpressure: three pushes against a stalled register file
        bus.wb_ready = 1'b0;
        set_in(ALU_OP_ADD, 16'd1, 5'b0, 4'd1, 1'b1, 1'b0);
        step();
        chk("bp_ready1", bus.in_ready, 1'b1);
        set_in(ALU_OP_ADD, 16'd2, 5'b0, 4'd2, 1'b1, 1'b0);
        step();
        chk("bp_ready2", bus.in_ready, 1'b0);
        set_in(ALU_OP_ADD, 16'd3, 5'b0, 4'd3, 1'b1, 1'b0);
        step();
        chk("bp_hold_ready", bus.in_ready, 1'b0);
        chk("bp_head1", bus.wb_data, 16'd1);
        bus.wb_ready = 1'b1;
        step();
        chk("bp_ready_after_pop", bus.in_ready, 1'b1);
        chk("bp_head2", bus.wb_data, 16'd2);
        step();
        idle();
        chk("bp_head3", bus.wb_data, 16'd3);
        step();
        chk("bp_empty", bus.wb_valid, 1'b0);

        // Simultaneous push and pop at count=1
        bus.wb_ready = 1'b0;
        set_in(ALU_OP_OR, 16'h00AA, 5'b0, 4'd7, 1'b1, 1'b0);
        step();
        set_in(ALU_OP_OR, 16'h0055, 5'b0, 4'd8, 1'b1, 1'b0);
        bus.wb_ready = 1'b1;
        step();
        idle();
        chk("pp_valid", bus.wb_valid, 1'b1);
        chk("pp_data", bus.wb_data, 16'h0055);
        chk("pp_ready", bus.in_ready, 1'b1);
        step();
        chk("pp_drained", bus.wb_valid, 1'b0);

        // sr_load beats the instruction's flags
        sr_load = 1'b1;
        sr_wdata = 5'b00001;
        set_in(ALU_OP_SUB, 16'h0, 5'b11000, 4'd0, 1'b0, 1'b1);
        step();
        idle();
        chk("ld_sr", sr_w, 5'b00001);
        cond_lit("ld_cs", COND_CS, 1'b1);
        cond_lit("ld_lt", COND_LT, 1'b0);

        // Reset with a full FIFO and SR set
        bus.wb_ready = 1'b0;
        set_in(ALU_OP_ADD, 16'h0011, 5'b0, 4'd9, 1'b1, 1'b0);
        step();
        set_in(ALU_OP_ADD, 16'h0022, 5'b0, 4'd10, 1'b1, 1'b0);
        sr_load = 1'b1;
        sr_wdata = 5'b11111;
        step();
        idle();
        chk("pre_rst_full", bus.in_ready, 1'b0);
        chk("pre_rst_sr", sr_w, 5'b11111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", bus.wb_valid, 1'b0);
        chk("mid_rst_ready", bus.in_ready, 1'b1);
        chk("mid_rst_sr", sr_w, 5'b00000);
        cond_lit("mid_rst_al", COND_AL, 1'b1);
        cond_lit("mid_rst_nv", COND_NV, 1'b0);
        bus.wb_ready = 1'b1;
        step();
        step();
        chk("no_stale_wb", bus.wb_valid, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            bus.in_valid = $urandom_range(0, 1);
            bus.in_ctrl  = 4'($urandom_range(0, 15));
            bus.in_y     = 16'($urandom);
            bus.in_flags = 5'($urandom);
            bus.in_dest  = 4'($urandom);
            bus.in_wen   = ($urandom_range(0, 3) != 0);
            bus.in_fwe   = $urandom_range(0, 1);
            bus.wb_ready = ($urandom_range(0, 2) != 0);
            sr_load      = ($urandom_range(0, 15) == 0);
            sr_wdata     = 5'($urandom);
            cond_sel     = 4'($urandom);
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
